// File: rtl/huffman_pkg.sv
// Shared widths and state encoding for the Huffman encoder and its bit packer.
package huffman_pkg;

    localparam int DEF_CODE_W = 8;
    localparam int DEF_LEN_W  = 4;
    localparam int DEF_WORD_W = 16;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

endpackage

// File: rtl/huffman_bit_buffer.sv
// Left-aligned bit buffer: optional word pop (shift left) followed by a masked
// insert of the new code directly behind the bits that remain after the pop.
module huffman_bit_buffer #(
    parameter int CODE_W = 8,
    parameter int LEN_W  = 4,
    parameter int WORD_W = 16,
    parameter int BUF_W  = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              pop,
    input  logic              accept,
    input  logic [CNT_W-1:0]  rem,
    input  logic [CODE_W-1:0] code_in,
    input  logic [LEN_W-1:0]  length_in,
    output logic [BUF_W-1:0]  bits
);

    localparam int SUM_W = CNT_W + 1;

    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] code_mask;
    logic [BUF_W-1:0] insert;
    logic [SUM_W-1:0] offset;

    always_comb begin
        shifted   = pop ? (bits << WORD_W) : bits;
        code_mask = (BUF_W'(1) << length_in) - BUF_W'(1);
        // Only meaningful on accept, where rem + length_in <= BUF_W.
        offset    = SUM_W'(BUF_W) - {1'b0, rem} - SUM_W'(length_in);
        insert    = (BUF_W'(code_in) & code_mask) << offset;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bits <= '0;
        end else begin
            bits <= accept ? (shifted | insert) : shifted;
        end
    end

endmodule

// File: rtl/huffman_bit_packer.sv
// Packs the encoder's variable-length codes MSB-first into WORD_W words, with a
// flush that emits the zero-padded tail word and pulses flush_done.
module huffman_bit_packer
    import huffman_pkg::*;
#(
    parameter int CODE_W = DEF_CODE_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] code_in,
    input  logic [LEN_W-1:0]  length_in,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_word,
    output logic              out_last,
    output logic              flush_done,
    output logic [LEN_W+1:0]  bit_count,
    output logic              error
);

    localparam int BUF_W = 2 * WORD_W;
    localparam int CNT_W = LEN_W + 2;
    localparam int SUM_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_W);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(CODE_W);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [BUF_W-1:0] buf_bits;
    logic             err_q;
    logic             done_q;

    logic             have_word;
    logic             tail;
    logic             pop;
    logic [CNT_W-1:0] rem;
    logic             fits;
    logic             accept;
    logic [CNT_W-1:0] next_count;

    // Outputs decode purely from registered state; in_* only affect the next edge.
    always_comb begin
        have_word  = (count >= WORD_CNT);
        tail       = (state == ST_FLUSH) && (count != '0) && !have_word;
        out_valid  = have_word | tail;
        out_last   = tail;
        out_word   = buf_bits[BUF_W-1 -: WORD_W];
        pop        = out_valid & out_ready;
        rem        = !pop ? count : (tail ? '0 : count - WORD_CNT);
        fits       = ({1'b0, rem} + SUM_W'(length_in)) <= SUM_W'(BUF_W);
        accept     = in_valid && (state == ST_RUN) && (length_in <= LEN_MAX) && fits;
        next_count = accept ? rem + CNT_W'(length_in) : rem;
    end

    huffman_bit_buffer #(
        .CODE_W (CODE_W),
        .LEN_W  (LEN_W),
        .WORD_W (WORD_W),
        .BUF_W  (BUF_W),
        .CNT_W  (CNT_W)
    ) u_buffer (
        .clock     (clock),
        .reset_n   (reset_n),
        .pop       (pop),
        .accept    (accept),
        .rem       (rem),
        .code_in   (code_in),
        .length_in (length_in),
        .bits      (buf_bits)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_RUN;
            count  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            count  <= next_count;
            err_q  <= err_q | (in_valid & ~accept);
            done_q <= 1'b0;
            case (state)
                ST_RUN: begin
                    // A flush that leaves nothing buffered completes without a word.
                    if (flush) begin
                        if (next_count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (next_count == '0) begin
                        done_q <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign flush_done = done_q;
    assign error      = err_q;
    assign bit_count  = count;

endmodule

// File: doc/huffman_bit_packer.md
# huffman_bit_packer

Downstream stage of `Huffman_encoder`: consumes the variable-length code stream (`data_out_code`, `data_out_length`, qualified by `data_out_state`) and packs it MSB-first into fixed-width words for the output FIFO or serial link. The encoder has no backpressure, so the packer accepts a code every cycle and buffers up to two words. A flush request drains the final partial word, zero-padded.

## Interface
- `CODE_W`, 8: maximum code length in bits, matching the encoder code width.
- `LEN_W`, 4: width of the length field.
- `WORD_W`, 16: output word width. `BUF_W` = 2*`WORD_W` (derived).
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: code present; driven by encoder `data_out_state`.
- `code_in` in `CODE_W`: code, right-aligned; only the low `length_in` bits are used.
- `length_in` in `LEN_W`: code length, 0..`CODE_W`.
- `flush` in 1: single-cycle request to drain the remaining bits.
- `out_ready` in 1: downstream accepts `out_word`.
- `out_valid` out 1: `out_word` valid.
- `out_word` out `WORD_W`: packed bits; the first-received bit is at the MSB.
- `out_last` out 1: marks the word that completes a flush.
- `flush_done` out 1: one-cycle pulse when the flush completes.
- `bit_count` out `LEN_W`+2: bits currently buffered, 0..`BUF_W`.
- `error` out 1: sticky error; cleared only by reset.

## Operation
- Buffer `buf[BUF_W-1:0]` holds valid bits left-aligned in `buf[BUF_W-1 -: bit_count]`.
- pop = `out_valid & out_ready`. On pop, shift the buffer left by `WORD_W`; bit_count -= `WORD_W` (or to 0 for a flush word).
- accept = `in_valid & ~flush_pending & length_in <= CODE_W`, and the post-pop count + `length_in` must be <= `BUF_W`.
  - On accept, write `code_in[length_in-1:0]` immediately after the post-pop remaining bits.
  - bit_count = remaining + `length_in`.
- Pop and accept in the same cycle are both applied.
- `length_in` = 0 with `in_valid`: accepted, no change.
- Dropped code: caused by `length_in > CODE_W`, buffer overflow, or `in_valid` while flush is pending. The code is discarded, `error` is set, and bit_count is unchanged apart from any pop.
- FSM states: RUN, FLUSH.
  - RUN: `out_valid` = (bit_count >= `WORD_W`), `out_word` = `buf[BUF_W-1 -: WORD_W]`. `flush` moves to FLUSH; `flush_pending` = (state == FLUSH). A code arriving in the same cycle as `flush` is accepted first and included in the flush.
  - FLUSH: full words drain as in RUN.
    - When 0 < bit_count < `WORD_W`: `out_valid` = 1, `out_word` = remaining bits with zero padding, `out_last` = 1. On pop, bit_count → 0, `flush_done` pulses, state → RUN.
    - When bit_count == 0: `flush_done` pulses that cycle with no word emitted, state → RUN.
- `flush` while already in FLUSH: ignored.
- Reset values: state RUN, buf 0, bit_count 0, `out_valid` 0, `out_word` 0, `out_last` 0, `flush_done` 0, `error` 0. Reset asserted mid-operation discards all buffered bits immediately.

## Timing
- `out_valid`, `out_word`, and `out_last` decode from registers only; there is no combinational path from `in_*`.
- Latency: a code accepted at edge N that fills a word gives `out_valid` = 1 after edge N, in cycle N+1.
- `out_word` is held stable while `out_valid & ~out_ready`.
- Sustained throughput: `WORD_W` bits per cycle out, `CODE_W` bits per cycle in, so no overflow occurs while `out_ready` stays high.
- Flush tail: `flush_done` is registered and pulses in the cycle after the pop of the last word (or after the flush edge when empty).

## Structure
- Shared package `huffman_pkg`: `CODE_W`, `LEN_W`, `WORD_W` defaults, and the state enum `{ST_RUN, ST_FLUSH}`. The encoder uses the same widths.
- One sub-module, `huffman_bit_buffer`: the shift-and-insert datapath (pop shift, masked insert at offset). The FSM, counters, and error logic stay in the top level.

## Test plan
- Eight codes of 2'b10, length 2, `out_ready` = 1 → one word `16'hAAAA`, `out_valid` in the cycle after the 8th code, `out_last` = 0.
- Three codes of 3'b101, length 3, then `flush` → `out_word` = `16'hB680`, `out_last` = 1, then `flush_done` pulse, bit_count 0.
- `out_ready` = 0, four codes of 8'hFF length 8, then a fifth → bit_count 32, `out_valid` = 1, fifth code dropped, `error` = 1. Releasing `out_ready` → two words of `16'hFFFF`.
- Simultaneous events: bit_count = 16, `out_ready` = 1, code 8'h5A length 8 in the same cycle → pop `16'h…`, next bit_count = 8, buffer top byte 8'h5A.
- `length_in` = 9 → dropped, `error` = 1. `length_in` = 0 → no change, no error. `flush` with bit_count 0 → `flush_done` with no word.
- `reset_n` low for one cycle with 12 bits buffered and FLUSH pending → all outputs 0, state RUN. A following 8× 2'b10 sequence gives `16'hAAAA`.
